// File: rtl/proc_pkg.sv
// Shared processor definitions: data-memory widths, core count and the
// DM arbiter state type used by the control units and datapaths.
package proc_pkg;

    localparam int DM_DATA_W    = 16;
    localparam int DM_ADDR_W    = 16;
    localparam int DM_NUM_CORES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection for the DM arbiter: round-robin after
// last_winner, or lowest-index-first when DMEM_ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     last_winner,
    output logic [NUM_CORES-1:0] gnt,
    output logic [IDX_W-1:0]     idx
);

    logic hit;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic unused_last_winner;
    assign unused_last_winner = ^last_winner;

    always_comb begin
        idx = '0;
        hit = 1'b0;
        // Scan from the top so the lowest requesting index is the last to overwrite.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                hit = 1'b1;
            end
        end
        gnt = hit ? (NUM_CORES'(1) << idx) : '0;
    end
`else
    logic [IDX_W-1:0] cand;

    always_comb begin
        idx  = '0;
        hit  = 1'b0;
        cand = '0;
        // Walk offsets from farthest to nearest; the core right after last_winner wins.
        for (int i = NUM_CORES; i >= 1; i--) begin
            cand = IDX_W'((int'(last_winner) + i) % NUM_CORES);
            if (req[cand]) begin
                idx = cand;
                hit = 1'b1;
            end
        end
        gnt = hit ? (NUM_CORES'(1) << idx) : '0;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous data memory between NUM_CORES cores, one access per
// three cycles. Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (core 0 first).
module dmem_arbiter
    import proc_pkg::*;
#(
    parameter int NUM_CORES = DM_NUM_CORES,
    parameter int ADDR_W    = DM_ADDR_W,
    parameter int DATA_W    = DM_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = $clog2(NUM_CORES);

    // Handshake: a core holds req (with we/addr/wdata stable) until it sees
    // ack; on the edge that samples ack it drops req or presents its next
    // access. The request is committed once latched in IDLE and cannot be
    // withdrawn; a req still high in the following IDLE is a new access.

    arb_state_t state, state_nxt;

    logic [NUM_CORES-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     last_winner;
    logic [NUM_CORES-1:0] win_onehot;
    logic                 lat_we;
    logic [ADDR_W-1:0]    lat_addr;
    logic [DATA_W-1:0]    lat_wdata;
    logic [DATA_W-1:0]    rdata_q;

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req         (req),
        .last_winner (last_winner),
        .gnt         (pick_gnt),
        .idx         (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pick_gnt) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_idx     <= '0;
            last_winner <= IDX_W'(NUM_CORES - 1);
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rdata_q     <= '0;
        end else begin
            if (state == IDLE && |pick_gnt) begin
                win_idx   <= pick_idx;
                lat_we    <= we[pick_idx];
                lat_addr  <= addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                lat_wdata <= wdata[int'(pick_idx)*DATA_W +: DATA_W];
            end
            if (state == RESP) begin
                last_winner <= win_idx;
                if (!lat_we) rdata_q <= mem_rdata;
            end
        end
    end

    // The RAM output register feeds rdata straight through during RESP so the
    // read data lines up with ack; otherwise the last read value is held.
    always_comb begin
        win_onehot = NUM_CORES'(1) << win_idx;
        gnt        = (state == ACCESS) ? win_onehot : '0;
        ack        = (state == RESP) ? win_onehot : '0;
        mem_en     = (state == ACCESS);
        mem_we     = (state == ACCESS) && lat_we;
        mem_addr   = (state == ACCESS) ? lat_addr : '0;
        mem_wdata  = (state == ACCESS) ? lat_wdata : '0;
        rdata      = (state == RESP && !lat_we) ? mem_rdata : rdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural DM RAM, per-core request
// lists, and a scoreboard of expected grants/acks in arrival order.
module tb_dmem_arbiter;
    import proc_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int EW = 1 + 3 + AW + DW;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N-1:0]      we;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      gnt;
    logic [N-1:0]      ack;
    logic [DW-1:0]     rdata;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    logic [DW-1:0] dm [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dm[mem_addr] <= mem_wdata;
            else        mem_rdata    <= dm[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    // entry = {is_read, core[2:0], addr, data}
    logic [EW-1:0] exp_q[$];
    int            gnt_cyc_q[$];
    int            ack_cyc_q[$];
    logic [DW-1:0] last_rd;

    task automatic push_exp(input int c, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({rd, 3'(c), a, d});
    endtask

    logic [EW-1:0] e;
    logic [N-1:0]  e_oh;
    always @(negedge clk) begin
        if (gnt != '0) begin
            gnt_cyc_q.push_back(cyc);
            check("gnt_onehot", 32'($countones(gnt)), 1);
            if (exp_q.size() == 0) begin
                check("gnt_unexpected", gnt, 0);
            end else begin
                e    = exp_q[0];
                e_oh = '0;
                e_oh[e[EW-2 -: 3]] = 1'b1;
                check("gnt_core", gnt, e_oh);
                check("mem_en", mem_en, 1);
                check("mem_we", mem_we, !e[EW-1]);
                check("mem_addr", mem_addr, e[AW+DW-1 -: AW]);
                if (!e[EW-1]) check("mem_wdata", mem_wdata, e[DW-1:0]);
            end
        end
        if (ack != '0) begin
            ack_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("ack_unexpected", ack, 0);
            end else begin
                e    = exp_q.pop_front();
                e_oh = '0;
                e_oh[e[EW-2 -: 3]] = 1'b1;
                check("ack_core", ack, e_oh);
                if (e[EW-1]) begin
                    check("rdata", rdata, e[DW-1:0]);
                    last_rd = e[DW-1:0];
                end else begin
                    check("rdata_hold", rdata, last_rd);
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic          op_we    [N][16];
    logic [AW-1:0] op_addr  [N][16];
    logic [DW-1:0] op_wdata [N][16];
    int            n_ops    [N];
    int            op_ptr   [N];

    task automatic add_op(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_we[c][n_ops[c]]    = w;
        op_addr[c][n_ops[c]]  = a;
        op_wdata[c][n_ops[c]] = d;
        n_ops[c]++;
    endtask

    task automatic load_req(input int c);
        if (op_ptr[c] < n_ops[c]) begin
            req[c]           = 1'b1;
            we[c]            = op_we[c][op_ptr[c]];
            addr[c*AW +: AW] = op_addr[c][op_ptr[c]];
            wdata[c*DW +: DW] = op_wdata[c][op_ptr[c]];
        end else begin
            req[c] = 1'b0;
            we[c]  = 1'b0;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run(input int max_cycles);
        int           k;
        logic [N-1:0] a;
        bit           busy;
        for (int c = 0; c < N; c++) begin
            op_ptr[c] = 0;
            load_req(c);
        end
        k    = 0;
        busy = 1'b1;
        while (busy && k < max_cycles) begin
            @(negedge clk);
            a = ack;
            @(posedge clk);
            #1;
            for (int c = 0; c < N; c++) begin
                if (a[c]) begin
                    op_ptr[c]++;
                    load_req(c);
                end
            end
            k++;
            busy = (exp_q.size() != 0);
            for (int c = 0; c < N; c++) if (op_ptr[c] < n_ops[c]) busy = 1'b1;
        end
        check("run_drained", exp_q.size(), 0);
        for (int c = 0; c < N; c++) n_ops[c] = 0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        last_rd = '0;
        exp_q.delete();
        gnt_cyc_q.delete();
        ack_cyc_q.delete();
    endtask

    task automatic clear_times();
        gnt_cyc_q.delete();
        ack_cyc_q.delete();
    endtask

    // ---------------- tests ----------------
    int t0;
    initial begin
        for (int c = 0; c < N; c++) n_ops[c] = 0;
        last_rd = '0;
        rst     = 1'b1;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        do_reset();

        // single read by core 2
        dm[16'h0010] = 16'h1234;
        add_op(2, 1'b0, 16'h0010, 16'h0);
        push_exp(2, 1'b1, 16'h0010, 16'h1234);
        clear_times();
        t0 = cyc;
        run(50);
        check("t1_gnt_cycle", gnt_cyc_q[0] - t0, 1);
        check("t1_ack_cycle", ack_cyc_q[0] - t0, 2);

        // write then read-back by core 1
        dm[16'h0020] = 16'h0000;
        add_op(1, 1'b1, 16'h0020, 16'hBEEF);
        add_op(1, 1'b0, 16'h0020, 16'h0);
        push_exp(1, 1'b0, 16'h0020, 16'hBEEF);
        push_exp(1, 1'b1, 16'h0020, 16'hBEEF);
        clear_times();
        run(50);
        check("t2_dm_written", dm[16'h0020], 16'hBEEF);
        check("t2_ack_gap", ack_cyc_q[1] - ack_cyc_q[0], 3);

        // reset asserted during a write's ACCESS cycle
        do_reset();
        dm[16'h0005] = 16'h0000;
        req[0]       = 1'b1;
        we[0]        = 1'b1;
        addr[0 +: AW]  = 16'h0005;
        wdata[0 +: DW] = 16'hA5A5;
        push_exp(0, 1'b0, 16'h0005, 16'hA5A5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = '0;
        we  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t3_no_ack", exp_q.size(), 1);
        exp_q.delete();
        @(negedge clk);
        check("t3_gnt_zero", gnt, 0);
        check("t3_ack_zero", ack, 0);
        check("t3_mem_en_zero", mem_en, 0);
        check("t3_rdata_zero", rdata, 0);
        check("t3_dm_written", dm[16'h0005], 16'hA5A5);
        repeat (3) @(posedge clk);
        #1;

        // all four cores request together; service starts at core 0
        for (int c = 0; c < N; c++) begin
            dm[16'h0100 + 16'(c)] = 16'h1000 + 16'(c);
            add_op(c, 1'b0, 16'h0100 + 16'(c), 16'h0);
            push_exp(c, 1'b1, 16'h0100 + 16'(c), 16'h1000 + 16'(c));
        end
        clear_times();
        t0 = cyc;
        run(100);
        for (int k = 0; k < N; k++) check("t4_ack_cycle", ack_cyc_q[k] - t0, 2 + 3 * k);

        // fairness: cores 1 and 3 re-request continuously
        dm[16'h0040] = 16'h4141;
        for (int k = 0; k < 10; k++) begin
            add_op(1, 1'b0, 16'h0040, 16'h0);
            add_op(3, 1'b1, 16'h0300 + 16'(k), 16'h3000 + 16'(k));
            push_exp(1, 1'b1, 16'h0040, 16'h4141);
            push_exp(3, 1'b0, 16'h0300 + 16'(k), 16'h3000 + 16'(k));
        end
        clear_times();
        run(200);
        check("t5_span", ack_cyc_q[19] - ack_cyc_q[0], 57);
        check("t5_dm_last", dm[16'h0309], 16'h3009);

        // cores 0 and 2 continuous (last winner is core 3)
        dm[16'h0050] = 16'h5050;
        dm[16'h0052] = 16'h5252;
        for (int k = 0; k < 6; k++) begin
            add_op(0, 1'b0, 16'h0050, 16'h0);
            add_op(2, 1'b0, 16'h0052, 16'h0);
        end
`ifdef DMEM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 6; k++) push_exp(0, 1'b1, 16'h0050, 16'h5050);
        for (int k = 0; k < 6; k++) push_exp(2, 1'b1, 16'h0052, 16'h5252);
`else
        for (int k = 0; k < 6; k++) begin
            push_exp(0, 1'b1, 16'h0050, 16'h5050);
            push_exp(2, 1'b1, 16'h0052, 16'h5252);
        end
`endif
        clear_times();
        run(200);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
